// File: rtl/match_vector_driver.sv
// match_vector_driver
// Hardware initiator for the enum-match test protocol. It walks test-case
// indices 0..NUM_CASES-1 onto a variant bus and holds each one for
// SETTLE_CYCLES. It then samples the decoder's result and checks it against
// a packed expected-value table. The outcome is reported as pass/fail, a
// saturating mismatch count and the first failing index, so a hardware test
// can check itself without help from a bench.
module match_vector_driver #(
    parameter int WIDTH         = 8,
    parameter int NUM_CASES     = 3,
    parameter int SETTLE_CYCLES = 1,
    parameter logic [NUM_CASES*WIDTH-1:0] EXP_TABLE = {8'd3, 8'd2, 8'd0}
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_result,
    output logic [WIDTH-1:0] o_variant,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [7:0]       o_err_count,
    output logic [7:0]       o_first_fail
);

    // 8'hFF marks "no failure yet". It can never be a real index because
    // the largest index is NUM_CASES-1 <= 254.
    localparam logic [7:0] NO_FAIL  = 8'hFF;
    localparam logic [7:0] LAST_IDX = 8'(NUM_CASES - 1);
    localparam logic [7:0] SETTLE   = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [7:0]       r_idx;
    logic [7:0]       r_cnt;
    logic [WIDTH-1:0] r_variant;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [7:0]       r_errCount;
    logic [7:0]       r_firstFail;

    logic [WIDTH-1:0] w_expected;
    logic             w_match;
    logic             w_lastCase;
    logic [7:0]       w_nextIdx;
    logic [WIDTH-1:0] w_nextVariant;
    logic [7:0]       w_errInc;

    // Select the expected result for the current index from the packed table.
    always_comb begin
        w_expected = '0;
        for (int k = 0; k < NUM_CASES; k++) begin
            if (r_idx == 8'(k)) begin
                w_expected = EXP_TABLE[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_match       = (i_result == w_expected);
    assign w_lastCase    = (r_idx == LAST_IDX);
    assign w_nextIdx     = r_idx + 8'd1;
    assign w_nextVariant = WIDTH'(w_nextIdx);
    assign w_errInc      = (r_errCount == 8'hFF) ? 8'hFF : (r_errCount + 8'd1);

    // Run sequencer: this is the only block that updates the registered
    // results. Reset takes priority over start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= 8'd0;
            r_cnt       <= 8'd0;
            r_variant   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_errCount  <= 8'd0;
            r_firstFail <= NO_FAIL;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state     <= ST_RUN;
                        r_idx       <= 8'd0;
                        r_variant   <= '0;
                        r_cnt       <= SETTLE;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_errCount  <= 8'd0;
                        r_firstFail <= NO_FAIL;
                    end
                end
                ST_RUN: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        if (!w_match) begin
                            r_errCount <= w_errInc;
                            if (r_firstFail == NO_FAIL) begin
                                r_firstFail <= r_idx;
                            end
                        end
                        if (!w_lastCase) begin
                            r_idx     <= w_nextIdx;
                            r_variant <= w_nextVariant;
                            r_cnt     <= SETTLE;
                        end else begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= w_match && (r_errCount == 8'd0);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_variant    = r_variant;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_count  = r_errCount;
    assign o_first_fail = r_firstFail;

endmodule

// File: tb/tb_match_vector_driver.sv
// tb_match_vector_driver
// This bench drives two driver instances, each connected to a behavioural
// decoder model. The decoder model is a lookup array indexed by the variant.
// Instance A uses the default parameters: 3 cases and one settle cycle.
// Instance B uses 255 cases with no settle cycle.
// Expected outcomes come from a reference model that loops over the cases
// and applies the mismatch rules directly.
module tb_match_vector_driver;

    // Latencies from start edge to done, derived from NUM_CASES*(SETTLE+1)
    localparam int LAT_A = 3 * (1 + 1);
    localparam int LAT_B = 255 * (0 + 1);

    // Expected table for instance B: case k expects k*7+1 (mod 256)
    function automatic logic [255*8-1:0] buildExpB();
        logic [255*8-1:0] t;
        t = '0;
        for (int k = 0; k < 255; k++) t[k*8 +: 8] = 8'(k * 7 + 1);
        return t;
    endfunction
    localparam logic [255*8-1:0] EXP_B = buildExpB();

    logic       clk = 1'b0;
    logic       rst;
    logic       startA, startB;
    logic [7:0] resultA, variantA, errA, firstA;
    logic       busyA, doneA, passA;
    logic [7:0] resultB, variantB, errB, firstB;
    logic       busyB, doneB, passB;

    logic [7:0] mapA [0:255];
    logic [7:0] mapB [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // The decoders under test are pure lookups, so they are combinational.
    assign resultA = mapA[variantA];
    assign resultB = mapB[variantB];

    match_vector_driver dutA (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (startA),
        .i_result     (resultA),
        .o_variant    (variantA),
        .o_busy       (busyA),
        .o_done       (doneA),
        .o_pass       (passA),
        .o_err_count  (errA),
        .o_first_fail (firstA)
    );

    match_vector_driver #(
        .WIDTH         (8),
        .NUM_CASES     (255),
        .SETTLE_CYCLES (0),
        .EXP_TABLE     (EXP_B)
    ) dutB (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (startB),
        .i_result     (resultB),
        .o_variant    (variantB),
        .o_busy       (busyB),
        .o_done       (doneB),
        .o_pass       (passB),
        .o_err_count  (errB),
        .o_first_fail (firstB)
    );

    // Expected table for instance A, as written in the protocol description
    function automatic logic [7:0] specExpA(int k);
        case (k)
            0:       return 8'd0;
            1:       return 8'd2;
            default: return 8'd3;
        endcase
    endfunction

    // Reference model: scan the cases and count the mismatches, saturating
    // at 255. It also records the first mismatching index.
    task automatic modelRun(input bit isB, output logic [7:0] eErr,
                            output logic [7:0] eFirst, output logic ePass);
        int n;
        logic [7:0] want, got;
        n = isB ? 255 : 3;
        eErr = 8'd0;
        eFirst = 8'hFF;
        for (int k = 0; k < n; k++) begin
            want = isB ? 8'(k * 7 + 1) : specExpA(k);
            got  = isB ? mapB[k] : mapA[k];
            if (got != want) begin
                if (eFirst == 8'hFF) eFirst = 8'(k);
                if (eErr != 8'd255) eErr = eErr + 8'd1;
            end
        end
        ePass = (eErr == 8'd0);
    endtask

    // Pulse (or hold) start on A and count the edges until done is seen.
    // The count does not include the start edge.
    task automatic runA(input bit holdStart, output int edges, output bit ok);
        startA = 1'b1;
        edges = -1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!holdStart) startA = 1'b0;
            edges++;
            if (doneA) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic runB(output int edges, output bit ok);
        startB = 1'b1;
        edges = -1;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            startB = 1'b0;
            edges++;
            if (doneB) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic setCorrectA();
        for (int k = 0; k < 256; k++) mapA[k] = (k < 3) ? specExpA(k) : 8'h00;
    endtask

    // Reset held for two edges while start is high should leave both
    // instances idle at their reset values.
    task automatic test_reset();
        rst = 1'b1;
        startA = 1'b1;
        startB = 1'b1;
        repeat (2) @(negedge clk);
        if ({variantA, busyA, doneA, passA, errA, firstA} !== {8'd0, 3'b000, 8'd0, 8'hFF}) begin
            errors++;
            $display("[TB] FAIL reset_A: got %h required %h",
                     {variantA, busyA, doneA, passA, errA, firstA}, {8'd0, 3'b000, 8'd0, 8'hFF});
        end
        checks++;
        if ({variantB, busyB, doneB, passB, errB, firstB} !== {8'd0, 3'b000, 8'd0, 8'hFF}) begin
            errors++;
            $display("[TB] FAIL reset_B: got %h required %h",
                     {variantB, busyB, doneB, passB, errB, firstB}, {8'd0, 3'b000, 8'd0, 8'hFF});
        end
        checks++;
        rst = 1'b0;
        startA = 1'b0;
        startB = 1'b0;
        @(negedge clk);
        if ({busyA, doneA, busyB, doneB} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_idle: got %b required 0000", {busyA, doneA, busyB, doneB});
        end
        checks++;
    endtask

    // Step through a correct run cycle by cycle and check the variant
    // sequence 0,0,1,1,2,2 and then the done state.
    task automatic test_sequence();
        setCorrectA();
        startA = 1'b1;
        for (int c = 0; c < LAT_A; c++) begin
            @(negedge clk);
            startA = 1'b0;
            if ({variantA, busyA, doneA} !== {8'(c / 2), 1'b1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL seq_cycle%0d: variant/busy/done got %h/%b/%b required %h/1/0",
                         c, variantA, busyA, doneA, 8'(c / 2));
            end
            checks++;
        end
        @(negedge clk);
        if ({doneA, busyA, passA, errA, firstA, variantA} !== {3'b101, 8'd0, 8'hFF, 8'd2}) begin
            errors++;
            $display("[TB] FAIL seq_done: got %h required %h",
                     {doneA, busyA, passA, errA, firstA, variantA}, {3'b101, 8'd0, 8'hFF, 8'd2});
        end
        checks++;
    endtask

    // Faulty decoders: a single wrong case, then a decoder stuck at 7
    task automatic test_faulty();
        int edges;
        bit ok;
        logic [7:0] eErr, eFirst;
        logic ePass;
        for (int s = 0; s < 2; s++) begin
            setCorrectA();
            if (s == 0) mapA[1] = 8'd1;
            else for (int k = 0; k < 256; k++) mapA[k] = 8'd7;
            modelRun(1'b0, eErr, eFirst, ePass);
            runA(1'b0, edges, ok);
            if (!ok || edges != LAT_A) begin
                errors++;
                $display("[TB] FAIL faulty%0d_latency: got %0d (ok=%0d) required %0d", s, edges, ok, LAT_A);
            end
            checks++;
            if ({doneA, busyA, passA, errA, firstA} !== {1'b1, 1'b0, ePass, eErr, eFirst}) begin
                errors++;
                $display("[TB] FAIL faulty%0d_result: got %h required %h", s,
                         {doneA, busyA, passA, errA, firstA}, {1'b1, 1'b0, ePass, eErr, eFirst});
            end
            checks++;
        end
    endtask

    // Holding start through the run must not restart it. A new run begins
    // on the edge after done, and that edge clears the counters.
    task automatic test_start_held();
        int edges;
        bit ok;
        setCorrectA();
        mapA[1] = 8'd1;
        runA(1'b1, edges, ok);
        if (!ok || edges != LAT_A || errA !== 8'd1 || firstA !== 8'd1) begin
            errors++;
            $display("[TB] FAIL held_first_run: edges %0d err %0d first %0d required %0d 1 1",
                     edges, errA, firstA, LAT_A);
        end
        checks++;
        @(negedge clk);
        if ({busyA, doneA, passA, errA, firstA, variantA} !== {3'b100, 8'd0, 8'hFF, 8'd0}) begin
            errors++;
            $display("[TB] FAIL held_restart: got %h required %h",
                     {busyA, doneA, passA, errA, firstA, variantA}, {3'b100, 8'd0, 8'hFF, 8'd0});
        end
        checks++;
        startA = 1'b0;
        setCorrectA();
        edges = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            edges++;
            if (doneA) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok || edges != LAT_A || passA !== 1'b1) begin
            errors++;
            $display("[TB] FAIL held_second_run: edges %0d pass %b required %0d 1", edges, passA, LAT_A);
        end
        checks++;
    endtask

    // Reset asserted in the middle of a run aborts it. A fresh start after
    // the abort completes normally.
    task automatic test_reset_midrun();
        int edges;
        bit ok;
        setCorrectA();
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        startA = 1'b1;
        @(negedge clk);
        if ({variantA, busyA, doneA, passA, errA, firstA} !== {8'd0, 3'b000, 8'd0, 8'hFF}) begin
            errors++;
            $display("[TB] FAIL midrun_reset: got %h required %h",
                     {variantA, busyA, doneA, passA, errA, firstA}, {8'd0, 3'b000, 8'd0, 8'hFF});
        end
        checks++;
        rst = 1'b0;
        startA = 1'b0;
        @(negedge clk);
        runA(1'b0, edges, ok);
        if (!ok || edges != LAT_A || passA !== 1'b1 || errA !== 8'd0) begin
            errors++;
            $display("[TB] FAIL midrun_rerun: edges %0d pass %b err %0d required %0d 1 0",
                     edges, passA, errA, LAT_A);
        end
        checks++;
    endtask

    // Back-to-back randomized runs on A, each scored against the model.
    task automatic test_random();
        int edges;
        bit ok;
        logic [7:0] eErr, eFirst;
        logic ePass;
        for (int r = 0; r < 16; r++) begin
            setCorrectA();
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 1) == 0) mapA[k] = 8'($urandom);
            modelRun(1'b0, eErr, eFirst, ePass);
            runA(1'b0, edges, ok);
            if (!ok || edges != LAT_A ||
                {passA, errA, firstA, variantA} !== {ePass, eErr, eFirst, 8'd2}) begin
                errors++;
                $display("[TB] FAIL random%0d: edges %0d got %h required %h", r, edges,
                         {passA, errA, firstA, variantA}, {ePass, eErr, eFirst, 8'd2});
            end
            checks++;
        end
    endtask

    // Instance B: every case wrong drives the count to exactly 255 with no
    // wrap. Random and correct runs follow, with one compare per cycle.
    task automatic test_saturation();
        int edges;
        bit ok;
        logic [7:0] eErr, eFirst;
        logic ePass;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 256; k++) begin
                if (r == 0) mapB[k] = 8'(k * 7 + 2);
                else if (r == 3) mapB[k] = 8'(k * 7 + 1);
                else mapB[k] = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'(k * 7 + 1);
            end
            modelRun(1'b1, eErr, eFirst, ePass);
            runB(edges, ok);
            if (!ok || edges != LAT_B) begin
                errors++;
                $display("[TB] FAIL sat%0d_latency: got %0d (ok=%0d) required %0d", r, edges, ok, LAT_B);
            end
            checks++;
            if ({doneB, passB, errB, firstB, variantB} !== {1'b1, ePass, eErr, eFirst, 8'd254}) begin
                errors++;
                $display("[TB] FAIL sat%0d_result: got %h required %h", r,
                         {doneB, passB, errB, firstB, variantB}, {1'b1, ePass, eErr, eFirst, 8'd254});
            end
            checks++;
        end
    endtask

    // Watchdog: stop the run if it goes far beyond its expected length
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Run the scenarios in sequence, then print the summary
    initial begin
        rst = 1'b1;
        startA = 1'b0;
        startB = 1'b0;
        for (int k = 0; k < 256; k++) begin
            mapA[k] = 8'h00;
            mapB[k] = 8'(k * 7 + 1);
        end
        @(negedge clk);
        test_reset();
        test_sequence();
        test_faulty();
        test_start_held();
        test_reset_midrun();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
